// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_MUL     = 4'd2,
    OP_DIV     = 4'd3,
    OP_AND     = 4'd4,
    OP_OR      = 4'd5,
    OP_XOR     = 4'd6,
    OP_NOT     = 4'd7,
    OP_SHR     = 4'd8,
    OP_SHL     = 4'd9,
    OP_EQ      = 4'd10,
    OP_GT      = 4'd11,
    OP_LT      = 4'd12,
    OP_NE      = 4'd13,
    OP_BIT_SET = 4'd14,
    OP_BIT_CLR = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic negative;
    logic overflow;
    logic zero;
    logic div_zero;
  } flags_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one step per cycle.
// done pulses in the last step; result/overflow/div_zero are valid alongside it.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic             is_div;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mq_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_take;

  // acc holds the running high product (MUL) or the partial remainder (DIV);
  // mq shifts out multiplier bits / shifts in quotient bits.
  always_comb begin
    mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
    div_shift = {acc, mq[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_take  = ~div_diff[WIDTH] | (operand == '0);
    if (is_div) begin
      acc_next = div_take ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      mq_next  = {mq[WIDTH-2:0], div_take};
    end else begin
      acc_next = mul_sum[WIDTH:1];
      mq_next  = {mul_sum[0], mq[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      is_div  <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mq      <= '0;
      operand <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      is_div  <= (op == OP_DIV);
      count   <= '0;
      acc     <= '0;
      mq      <= a;
      operand <= b;
    end else if (busy) begin
      acc   <= acc_next;
      mq    <= mq_next;
      count <= count + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

  assign done     = busy && (count == CW'(WIDTH - 1));
  assign result   = mq_next;
  assign overflow = ~is_div && (acc_next != '0);
  assign div_zero = is_div && (operand == '0);

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake and registered result/flags.
// Define SEQ_ALU_MULDIV_EN to build the iterative MUL/DIV datapath; otherwise MUL/DIV
// finish in one cycle with result=0 and overflow=1.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             zero,
  output logic             div_zero
);

  localparam int KW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  op_t              op_e;
  flags_t           flags;
  flags_t           alu_flags;
  flags_t           md_flags;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] md_result;
  logic             md_done;
  logic             accept;
  logic             op_is_muldiv;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [KW-1:0]    shift_k;
  logic [KW-1:0]    shr_idx;
  logic [KW-1:0]    shl_idx;
  logic [WIDTH-1:0] bit_mask;

`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
  logic md_overflow;
  logic md_div_zero;

  seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && op_is_muldiv),
    .op       (op),
    .a        (a),
    .b        (b),
    .done     (md_done),
    .result   (md_result),
    .overflow (md_overflow),
    .div_zero (md_div_zero)
  );

  assign md_flags = '{carry: 1'b0, negative: md_result[WIDTH-1], overflow: md_overflow,
                      zero: (md_result == '0), div_zero: md_div_zero};
`else
  localparam bit MULDIV_EN = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
  assign md_flags  = '0;
`endif

  assign op_e         = op_t'(op);
  assign op_is_muldiv = MULDIV_EN && ((op_e == OP_MUL) || (op_e == OP_DIV));

  // Single-cycle datapath works straight off the inputs in the accept cycle.
  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign shift_k  = b[KW-1:0];
  assign shr_idx  = shift_k - KW'(1);
  assign shl_idx  = KW'(0) - shift_k;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign bit_mask[gi] = (shift_k == KW'(gi));
  end

  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    case (op_e)
      OP_ADD: begin
        alu_result         = add_full[WIDTH-1:0];
        alu_flags.carry    = add_full[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result         = sub_full[WIDTH-1:0];
        alu_flags.carry    = sub_full[WIDTH];
        alu_flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL, OP_DIV: alu_flags.overflow = 1'b1;
      OP_AND: alu_result = a & b;
      OP_OR:  alu_result = a | b;
      OP_XOR: alu_result = a ^ b;
      OP_NOT: alu_result = ~a;
      OP_SHR: begin
        alu_result      = a >> shift_k;
        alu_flags.carry = (shift_k != '0) && a[shr_idx];
      end
      OP_SHL: begin
        alu_result      = a << shift_k;
        alu_flags.carry = (shift_k != '0) && a[shl_idx];
      end
      OP_EQ:      alu_result = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_GT:      alu_result = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LT:      alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_NE:      alu_result = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_BIT_SET: alu_result = a | bit_mask;
      OP_BIT_CLR: alu_result = a & ~bit_mask;
    endcase
    alu_flags.negative = alu_result[WIDTH-1];
    alu_flags.zero     = (alu_result == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_ready is masked by rst so nothing is accepted while reset is held.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        accept   = ~rst & in_valid;
        if (accept) begin
          state_next = op_is_muldiv ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (md_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flags  <= '0;
    end else if (accept && !op_is_muldiv) begin
      result <= alu_result;
      flags  <= alu_flags;
    end else if (md_done) begin
      result <= md_result;
      flags  <= md_flags;
    end
  end

  assign carry    = flags.carry;
  assign negative = flags.negative;
  assign overflow = flags.overflow;
  assign zero     = flags.zero;
  assign div_zero = flags.div_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8); MUL/DIV expectations follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int WIDTH = 8;
`ifdef SEQ_ALU_MULDIV_EN
  localparam int MD_LAT = WIDTH + 1;
  localparam bit MD_ON  = 1'b1;
`else
  localparam int MD_LAT = 1;
  localparam bit MD_ON  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic             zero;
  logic             div_zero;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .negative  (negative),
    .overflow  (overflow),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  function automatic logic [4:0] flg();
    return {carry, negative, overflow, zero, div_zero};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble the inputs while waiting, check latency, result and flags, then drain.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic [7:0] exp_res,
                       input logic [4:0] exp_flags, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 4'($urandom);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_flags"}, 32'(flg()), 32'(exp_flags));
    $display("op=%0d a=0x%02h b=0x%02h result=0x%02h flags=%05b latency=%0d",
             o, x, y, result, flg(), lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    tick();
    tick();
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", 32'(flg()), 32'd0);
    rst = 1'b0;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);

    // flags order: {carry, negative, overflow, zero, div_zero}
    do_op("add_carry",   OP_ADD,     8'd250, 8'd10,  8'h04, 5'b10000, 1);
    do_op("sub_borrow",  OP_SUB,     8'd5,   8'd7,   8'hFE, 5'b11000, 1);
    do_op("add_ovf",     OP_ADD,     8'h7F,  8'h01,  8'h80, 5'b01100, 1);
    do_op("add_wrap0",   OP_ADD,     8'hFF,  8'h01,  8'h00, 5'b10010, 1);
    do_op("bit_clr",     OP_BIT_CLR, 8'hFF,  8'd3,   8'hF7, 5'b01000, 1);
    do_op("bit_set",     OP_BIT_SET, 8'h00,  8'd7,   8'h80, 5'b01000, 1);
    do_op("shl",         OP_SHL,     8'h81,  8'd1,   8'h02, 5'b10000, 1);
    do_op("shr",         OP_SHR,     8'h81,  8'd1,   8'h40, 5'b10000, 1);
    do_op("shr_k0",      OP_SHR,     8'h81,  8'd8,   8'h81, 5'b01000, 1);
    do_op("shl_k7",      OP_SHL,     8'h03,  8'd7,   8'h80, 5'b11000, 1);
    do_op("eq",          OP_EQ,      8'd5,   8'd5,   8'h01, 5'b00000, 1);
    do_op("gt",          OP_GT,      8'd3,   8'd200, 8'h00, 5'b00010, 1);
    do_op("lt",          OP_LT,      8'd3,   8'd200, 8'h01, 5'b00000, 1);
    do_op("xor_zero",    OP_XOR,     8'hAA,  8'hAA,  8'h00, 5'b00010, 1);
    do_op("not",         OP_NOT,     8'h0F,  8'h00,  8'hF0, 5'b01000, 1);
    do_op("mul_20x13",   OP_MUL,     8'd20,  8'd13,  MD_ON ? 8'h04 : 8'h00,
          MD_ON ? 5'b00100 : 5'b00110, MD_LAT);
    do_op("mul_3x3",     OP_MUL,     8'd3,   8'd3,   MD_ON ? 8'h09 : 8'h00,
          MD_ON ? 5'b00000 : 5'b00110, MD_LAT);
    do_op("div_100_7",   OP_DIV,     8'd100, 8'd7,   MD_ON ? 8'd14 : 8'h00,
          MD_ON ? 5'b00000 : 5'b00110, MD_LAT);
    do_op("div_by_zero", OP_DIV,     8'd100, 8'd0,   MD_ON ? 8'hFF : 8'h00,
          MD_ON ? 5'b01001 : 5'b00110, MD_LAT);

    // Consumer stalls in DONE while a new request is offered with changing inputs.
    op = OP_ADD;
    a = 8'd1;
    b = 8'd2;
    in_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 4'($urandom);
      tick();
      check("hold_result", 32'(result), 32'd3);
      check("hold_flags", 32'(flg()), 32'd0);
      check("hold_handshake", 32'({in_ready, out_valid}), 32'b01);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release", 32'({in_ready, out_valid}), 32'b10);
    $display("op=%0d a=0x01 b=0x02 result=0x03 held for 5 stalled cycles", OP_ADD);

`ifdef SEQ_ALU_MULDIV_EN
    // Reset lands in the 4th BUSY cycle of a MUL.
    op = OP_MUL;
    a = 8'd20;
    b = 8'd13;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_in_ready", 32'({in_ready, out_valid}), 32'b00);
    tick();
    tick();
    tick();
`else
    // Reset lands while a result waits in DONE.
    op = OP_ADD;
    a = 8'd250;
    b = 8'd10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("done_before_abort", 32'(out_valid), 32'd1);
`endif
    rst = 1'b1;
    tick();
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'(flg()), 32'd0);
    check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready_release", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    $display("op=%0d aborted by reset, no result produced", op);

    do_op("after_abort", OP_OR, 8'hA0, 8'h05, 8'hA5, 5'b01000, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
